spi_slave_rx: RTL

- SPI slave endpoint that sits directly downstream of the team's SPI master (sclk/mosi/cs generator with CPOL/CPHA control). It consumes the master's serial stream.
- Everything runs in the system clock domain: sclk, cs_n and mosi are synchronised and sampled.
- Each complete word is deserialised and presented on a valid/ready byte interface.
- A reply word is shifted out on miso at the same time.

---
 rtl/spi_slave_rx.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: synchronised sclk/cs_n/mosi, valid/ready word output, miso reply.
// Build option: define SPI_RX_LSB_FIRST_EN to shift LSB first in both directions.
module spi_slave_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun,
    output logic              frame_err,
    input  logic              err_clr,
    output logic              busy
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                   r_sclk_prev, r_cs_prev;
    logic                   r_cpol, r_cpha;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_W-1:0]      r_rx_shift, r_tx_shift, r_rx_data;
    logic                   r_word_done, r_rx_valid, r_overrun;
    logic                   r_miso, r_tx_load, r_frame_err;

    logic w_sclk, w_cs, w_mosi;
    logic w_edge, w_lead, w_trail, w_sample, w_shift;
    logic w_cs_fall, w_cs_rise;
    logic w_start, w_stop, w_smp, w_shf, w_ovr_set;
    logic              w_tx_bit, w_first_bit;
    logic [DATA_W-1:0] w_rx_next, w_tx_adv, w_tx_after;

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    assign w_edge    = w_sclk ^ r_sclk_prev;
    assign w_lead    = w_edge & (w_sclk ^ r_cpol);
    assign w_trail   = w_edge & ~(w_sclk ^ r_cpol);
    assign w_sample  = r_cpha ? w_trail : w_lead;
    assign w_shift   = r_cpha ? w_lead : w_trail;
    assign w_cs_fall = r_cs_prev & ~w_cs;
    assign w_cs_rise = ~r_cs_prev & w_cs;
    assign w_ovr_set = r_word_done & r_rx_valid & ~rx_ready;

`ifdef SPI_RX_LSB_FIRST_EN
    assign w_rx_next   = {w_mosi, r_rx_shift[DATA_W-1:1]};
    assign w_tx_bit    = r_tx_shift[0];
    assign w_tx_adv    = r_tx_shift >> 1;
    assign w_first_bit = tx_data[0];
    assign w_tx_after  = tx_data >> 1;
`else
    assign w_rx_next   = {r_rx_shift[DATA_W-2:0], w_mosi};
    assign w_tx_bit    = r_tx_shift[DATA_W-1];
    assign w_tx_adv    = r_tx_shift << 1;
    assign w_first_bit = tx_data[DATA_W-1];
    assign w_tx_after  = tx_data << 1;
`endif

    // Input synchronisers and previous-value flops for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs;
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state; sclk edges only count while selected
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_stop      = 1'b0;
        w_smp       = 1'b0;
        w_shf       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_start     = 1'b1;
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_cs_rise) begin
                    w_stop      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_smp = w_sample;
                    w_shf = w_shift;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shift registers, bit counter, mode latch and miso drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_miso      <= 1'b0;
            r_tx_load   <= 1'b0;
            r_frame_err <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_tx_load   <= 1'b0;
            r_frame_err <= 1'b0;
            r_word_done <= 1'b0;
            if (w_start) begin
                r_cpol     <= cpol;
                r_cpha     <= cpha;
                r_tx_shift <= cpha ? tx_data : w_tx_after;
                r_miso     <= w_first_bit;
                r_tx_load  <= 1'b1;
                r_bit_cnt  <= '0;
            end else if (w_stop) begin
                r_frame_err <= (r_bit_cnt != '0);
                r_bit_cnt   <= '0;
                r_miso      <= 1'b0;
            end else begin
                if (w_smp) begin
                    r_rx_shift <= w_rx_next;
                    if (r_bit_cnt == LAST_BIT) begin
                        r_bit_cnt   <= '0;
                        r_word_done <= 1'b1;
                        r_tx_shift  <= tx_data;
                        r_tx_load   <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                if (w_shf) begin
                    r_miso     <= w_tx_bit;
                    r_tx_shift <= w_tx_adv;
                end
            end
        end
    end

    // Received-word handshake and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (r_word_done) begin
                if (!(r_rx_valid && !rx_ready)) begin
                    r_rx_data  <= r_rx_shift;
                    r_rx_valid <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            if (w_ovr_set)    r_overrun <= 1'b1;
            else if (err_clr) r_overrun <= 1'b0;
        end
    end

    assign miso      = r_miso;
    assign miso_oe   = (r_state == ACTIVE);
    assign busy      = (r_state == ACTIVE);
    assign tx_load   = r_tx_load;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
endmodule
